// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle for the FFT bit-reversed-to-natural reorder stage.
// Upstream side: en_in/cnt_in/xin_*. Downstream side: en_out/cnt_out/yout_*/ovf.
// Optional macro BITREV_SOP_EOP_EN adds sop/eop frame markers.
interface fft_bitrev_reorder_if #(
  parameter int width = 16,
  parameter int N     = 9
);
  logic                    en_in;
  logic [N-1:0]            cnt_in;
  logic signed [width-1:0] xin_re;
  logic signed [width-1:0] xin_im;
  logic                    en_out;
  logic [N-1:0]            cnt_out;
  logic signed [width-1:0] yout_re;
  logic signed [width-1:0] yout_im;
  logic                    ovf;
`ifdef BITREV_SOP_EOP_EN
  logic                    sop;
  logic                    eop;
`endif

  modport master (
    output en_in, cnt_in, xin_re, xin_im,
`ifdef BITREV_SOP_EOP_EN
    input  sop, eop,
`endif
    input  en_out, cnt_out, yout_re, yout_im, ovf
  );

  modport slave (
    input  en_in, cnt_in, xin_re, xin_im,
`ifdef BITREV_SOP_EOP_EN
    output sop, eop,
`endif
    output en_out, cnt_out, yout_re, yout_im, ovf
  );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Reorders a bit-reversed FFT output stream into natural order using a
// ping-pong pair of 2^N-deep buffers (one written, one read).
// Optional macro BITREV_SOP_EOP_EN adds registered sop/eop outputs.
module fft_bitrev_reorder #(
  parameter int width = 16,
  parameter int N     = 9
) (
  input  logic               clk,
  input  logic               areset,
  fft_bitrev_reorder_if.slave io
);
  localparam int           DEPTH = 1 << N;
  localparam logic [N-1:0] LAST  = '1;

  typedef enum logic {IDLE, READ} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       rd_addr_q, rd_addr_d;
  logic               rd_bank_q, rd_bank_d;
  logic               wr_bank_q, wr_bank_d;
  logic [1:0]         full_q, full_d;
  logic               ovf_q, ovf_d;
  logic               rd_issue, rd_last;
  logic               wr_free, wr_en, wr_last;

  logic [2*width-1:0] mem [0:2*DEPTH-1];
  logic [2*width-1:0] rd_data_p1_q;
  logic               vld_p1_q, vld_p1_d;
  logic [N-1:0]       idx_p1_q, idx_p1_d;

  logic                    en_out_q, en_out_d;
  logic [N-1:0]            cnt_out_q, cnt_out_d;
  logic signed [width-1:0] yout_re_q, yout_re_d;
  logic signed [width-1:0] yout_im_q, yout_im_d;
`ifdef BITREV_SOP_EOP_EN
  logic                    sop_q, sop_d;
  logic                    eop_q, eop_d;
`endif

  function automatic logic [N-1:0] bitrev(input logic [N-1:0] a);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[N-1-i] = a[i];
    return r;
  endfunction

  // Read FSM: sweep a full bank sequentially, chaining straight into the other bank when it is ready
  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_bank_d = rd_bank_q;
    rd_issue  = 1'b0;
    rd_last   = 1'b0;
    case (state_q)
      IDLE: begin
        if (full_q[rd_bank_q]) begin
          state_d   = READ;
          rd_addr_d = '0;
        end
      end
      READ: begin
        rd_issue  = 1'b1;
        rd_addr_d = rd_addr_q + 1'b1;
        if (rd_addr_q == LAST) begin
          rd_last   = 1'b1;
          rd_bank_d = ~rd_bank_q;
          rd_addr_d = '0;
          state_d   = full_q[~rd_bank_q] ? READ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write side and bank flags: a bank whose last address is being read this edge
  // already counts as free, so a continuous 1 sample/clk stream never overruns
  always_comb begin
    wr_free   = !full_q[wr_bank_q] || (rd_last && (rd_bank_q == wr_bank_q));
    wr_en     = io.en_in && wr_free;
    wr_last   = wr_en && (io.cnt_in == LAST);
    wr_bank_d = wr_bank_q ^ wr_last;
    ovf_d     = ovf_q || (io.en_in && !wr_free);
    full_d    = full_q;
    if (rd_last) full_d[rd_bank_q] = 1'b0;
    if (wr_last) full_d[wr_bank_q] = 1'b1;
  end

  // Output stage inputs: zero index/data whenever no sample is valid
  always_comb begin
    vld_p1_d  = rd_issue;
    idx_p1_d  = rd_addr_q;
    en_out_d  = vld_p1_q;
    cnt_out_d = vld_p1_q ? idx_p1_q : '0;
    yout_re_d = vld_p1_q ? rd_data_p1_q[2*width-1:width] : '0;
    yout_im_d = vld_p1_q ? rd_data_p1_q[width-1:0] : '0;
`ifdef BITREV_SOP_EOP_EN
    sop_d     = vld_p1_q && (idx_p1_q == '0);
    eop_d     = vld_p1_q && (idx_p1_q == LAST);
`endif
  end

  // Stage p1: buffer RAM write and synchronous read (contents survive reset)
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank_q, bitrev(io.cnt_in)}] <= {io.xin_re, io.xin_im};
    rd_data_p1_q <= mem[{rd_bank_q, rd_addr_q}];
  end

  // Control state, shadow pipeline and stage p2 output registers
  always_ff @(posedge clk) begin
    if (areset) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_bank_q <= 1'b0;
      wr_bank_q <= 1'b0;
      full_q    <= 2'b00;
      ovf_q     <= 1'b0;
      vld_p1_q  <= 1'b0;
      idx_p1_q  <= '0;
      en_out_q  <= 1'b0;
      cnt_out_q <= '0;
      yout_re_q <= '0;
      yout_im_q <= '0;
`ifdef BITREV_SOP_EOP_EN
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_bank_q <= rd_bank_d;
      wr_bank_q <= wr_bank_d;
      full_q    <= full_d;
      ovf_q     <= ovf_d;
      vld_p1_q  <= vld_p1_d;
      idx_p1_q  <= idx_p1_d;
      en_out_q  <= en_out_d;
      cnt_out_q <= cnt_out_d;
      yout_re_q <= yout_re_d;
      yout_im_q <= yout_im_d;
`ifdef BITREV_SOP_EOP_EN
      sop_q     <= sop_d;
      eop_q     <= eop_d;
`endif
    end
  end

  assign io.en_out  = en_out_q;
  assign io.cnt_out = cnt_out_q;
  assign io.yout_re = yout_re_q;
  assign io.yout_im = yout_im_q;
  assign io.ovf     = ovf_q;
`ifdef BITREV_SOP_EOP_EN
  assign io.sop     = sop_q;
  assign io.eop     = eop_q;
`endif
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench for fft_bitrev_reorder with N=3 (8-point frames).
`timescale 1ns/1ps
module tb_fft_bitrev_reorder;
  localparam int W  = 16;
  localparam int NB = 3;
  localparam int FL = 8;

  logic clk = 1'b0;
  logic areset;
  always #5 clk = ~clk;

  fft_bitrev_reorder_if #(.width(W), .N(NB)) io ();
  fft_bitrev_reorder #(.width(W), .N(NB)) dut (.clk(clk), .areset(areset), .io(io));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int edge_n; int cnt; int re; int im; bit sop; bit eop;} obs_t;
  typedef struct {int cnt; int re; int im;} exp_t;
  typedef struct {int cnt_in; int re_in; int im_in; int exp_re; int exp_im;} vec_t;

  obs_t cap[$];
  exp_t exp_q[$];
  vec_t tbl[FL];
  int   exp_order[FL] = '{0, 4, 2, 6, 1, 5, 3, 7};

  // Output monitor, sampled on the falling edge
  always @(negedge clk) begin : mon
    obs_t o;
    if (io.en_out === 1'b1) begin
      o.edge_n = cyc;
      o.cnt    = int'(io.cnt_out);
      o.re     = int'(io.yout_re);
      o.im     = int'(io.yout_im);
`ifdef BITREV_SOP_EOP_EN
      o.sop    = io.sop;
      o.eop    = io.eop;
`else
      o.sop    = 1'b0;
      o.eop    = 1'b0;
`endif
      cap.push_back(o);
    end
  end

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    io.en_in  = 1'b0;
    io.cnt_in = '0;
    io.xin_re = '0;
    io.xin_im = '0;
  endtask

  // Natural index k is fed by the input sample whose index is k with its bits mirrored
  function automatic int rev(input int k);
    int r = 0;
    for (int i = 0; i < NB; i++) if (((k >> i) & 1) != 0) r += (1 << (NB - 1 - i));
    return r;
  endfunction

  task automatic send_frame(input int base, input bit gap, output int last_edge);
    for (int c = 0; c < FL; c++) begin
      io.en_in  = 1'b1;
      io.cnt_in = NB'(c);
      io.xin_re = W'(base + c);
      io.xin_im = W'(-(base + c));
      step();
      last_edge = cyc;
      if (gap) begin
        idle_in();
        step();
      end
    end
    idle_in();
  endtask

  task automatic wait_cap(input string name, input int n, input int budget);
    int b = 0;
    while (cap.size() < n && b < budget) begin
      step();
      b++;
    end
    repeat (4) step();
    chk(name, cap.size(), n);
  endtask

  task automatic check_frame(input string tag, input int off, input int base, input int start_edge);
    obs_t o;
    int   src;
    if (cap.size() < off + FL) begin
      chk({tag, "_len"}, cap.size(), off + FL);
      return;
    end
    for (int k = 0; k < FL; k++) begin
      o   = cap[off + k];
      src = base + rev(k);
      chk({tag, "_cnt"}, o.cnt, k);
      chk({tag, "_re"}, o.re, src);
      chk({tag, "_im"}, o.im, -src);
      chk({tag, "_edge"}, o.edge_n, start_edge + k);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int last, l0, l1, l2, hits, b;
    int fre[FL];
    int fim[FL];
    logic signed [W-1:0] rv;
    exp_t e;
    obs_t o;

    // Reset state
    areset = 1'b1;
    idle_in();
    step();
    step();
    chk("rst_en_out", io.en_out, 0);
    chk("rst_cnt_out", io.cnt_out, 0);
    chk("rst_yout_re", io.yout_re, 0);
    chk("rst_yout_im", io.yout_im, 0);
    chk("rst_ovf", io.ovf, 0);
    areset = 1'b0;
    step();

    // Scenario 1: single frame from a vector table
    for (int i = 0; i < FL; i++) tbl[i] = '{i, i, -i, exp_order[i], -exp_order[i]};
    cap.delete();
    for (int i = 0; i < FL; i++) begin
      io.en_in  = 1'b1;
      io.cnt_in = NB'(tbl[i].cnt_in);
      io.xin_re = W'(tbl[i].re_in);
      io.xin_im = W'(tbl[i].im_in);
      step();
    end
    last = cyc;
    idle_in();
    wait_cap("s1_count", FL, 40);
    if (cap.size() >= FL) begin
      for (int i = 0; i < FL; i++) begin
        chk("s1_cnt", cap[i].cnt, i);
        chk("s1_re", cap[i].re, tbl[i].exp_re);
        chk("s1_im", cap[i].im, tbl[i].exp_im);
        chk("s1_edge", cap[i].edge_n, last + 3 + i);
      end
    end
    chk("s1_en_after", io.en_out, 0);
    chk("s1_yout_after", io.yout_re, 0);
    chk("s1_ovf", io.ovf, 0);

    // Scenario 2: three back-to-back frames, no output bubble
    cap.delete();
    send_frame(0, 1'b0, l0);
    send_frame(8, 1'b0, l1);
    send_frame(16, 1'b0, l2);
    chk("s2_in_contig", l2 - l0, 16);
    wait_cap("s2_count", 3 * FL, 80);
    for (int f = 0; f < 3; f++) check_frame("s2", f * FL, 8 * f, l0 + 3 + f * FL);
`ifdef BITREV_SOP_EOP_EN
    for (int i = 0; i < cap.size(); i++) begin
      chk("s2_sop", cap[i].sop, (cap[i].cnt == 0) ? 1 : 0);
      chk("s2_eop", cap[i].eop, (cap[i].cnt == FL - 1) ? 1 : 0);
    end
`endif
    chk("s2_ovf", io.ovf, 0);

    // Scenario 3: en_in toggling every cycle
    cap.delete();
    send_frame(0, 1'b1, last);
    wait_cap("s3_count", FL, 40);
    check_frame("s3", 0, 0, last + 3);

    // Scenario 4: random data with random input gaps against the model queue
    cap.delete();
    exp_q.delete();
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < FL; c++) begin
        rv = W'($urandom);
        fre[c] = int'(rv);
        rv = W'($urandom);
        fim[c] = int'(rv);
        io.en_in  = 1'b1;
        io.cnt_in = NB'(c);
        io.xin_re = W'(fre[c]);
        io.xin_im = W'(fim[c]);
        step();
        idle_in();
        repeat ($urandom_range(0, 2)) step();
      end
      for (int k = 0; k < FL; k++) begin
        e.cnt = k;
        e.re  = fre[rev(k)];
        e.im  = fim[rev(k)];
        exp_q.push_back(e);
      end
    end
    wait_cap("s4_count", exp_q.size(), 200);
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      chk("s4_cnt", cap[i].cnt, exp_q[i].cnt);
      chk("s4_re", cap[i].re, exp_q[i].re);
      chk("s4_im", cap[i].im, exp_q[i].im);
    end
    chk("s4_ovf", io.ovf, 0);

    // Scenario 5: overrun while both banks are full
    cap.delete();
    send_frame(100, 1'b0, last);
    io.en_in  = 1'b1;
    io.cnt_in = NB'(FL - 1);
    io.xin_re = W'(555);
    io.xin_im = W'(-555);
    step();
    chk("s5_ovf_before", io.ovf, 0);
    io.xin_re = W'(777);
    io.xin_im = W'(-777);
    step();
    idle_in();
    chk("s5_ovf_set", io.ovf, 1);
    wait_cap("s5_count", 2 * FL, 60);
    check_frame("s5_f0", 0, 100, last + 3);
    if (cap.size() >= 2 * FL) begin
      chk("s5_f1_edge", cap[FL].edge_n, last + 3 + FL);
      chk("s5_f1_cnt7", cap[2 * FL - 1].cnt, FL - 1);
      chk("s5_f1_re7", cap[2 * FL - 1].re, 555);
      chk("s5_f1_im7", cap[2 * FL - 1].im, -555);
    end
    hits = 0;
    foreach (cap[i]) if (cap[i].re == 777) hits++;
    chk("s5_no_overrun_data", hits, 0);
    repeat (10) step();
    chk("s5_ovf_sticky", io.ovf, 1);

    // Scenario 6: reset in the middle of a readout
    cap.delete();
    send_frame(200, 1'b0, last);
    b = 0;
    while (!(io.en_out === 1'b1 && io.cnt_out == NB'(4)) && b < 20) begin
      step();
      b++;
    end
    chk("s6_reach_idx4", (io.en_out === 1'b1 && io.cnt_out == NB'(4)) ? 1 : 0, 1);
    areset = 1'b1;
    step();
    chk("s6_en_out", io.en_out, 0);
    chk("s6_cnt_out", io.cnt_out, 0);
    chk("s6_yout_re", io.yout_re, 0);
    chk("s6_yout_im", io.yout_im, 0);
    chk("s6_ovf", io.ovf, 0);
    areset = 1'b0;
    repeat (3) step();
    chk("s6_stopped", io.en_out, 0);
    cap.delete();
    send_frame(300, 1'b0, last);
    wait_cap("s6_count", FL, 40);
    check_frame("s6", 0, 300, last + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Output reorder stage placed directly downstream of the last fftstg in the radix-2 pipeline FFT chain. It consumes the stage's bit-reversed-order stream (en, cnt, re/im) and emits each 2^N-point frame in natural order. It uses a ping-pong pair of 2^N-deep dual-port buffers: one bank is written at bit-reversed addresses while the other is read sequentially.

Parameters:
width, 16, bit width of each real/imag sample
N, 9, log2 of FFT length; frame = 2^N samples

Ports:
clk  in  1  clock, all logic on rising edge
areset  in  1  reset; synchronous, active-high
en_in  in  1  input sample valid (connect to last fftstg en_out)
cnt_in  in  N  input sample index within frame, bit-reversed order
xin_re  in  width  signed input real
xin_im  in  width  signed input imag
en_out  out  1  output sample valid
cnt_out  out  N  natural-order output index
yout_re  out  width  signed output real
yout_im  out  width  signed output imag
ovf  out  1  sticky overrun flag

Behaviour:
- Storage: two banks, bank0/bank1, each 2^N x (2*width), synchronous read with 1-cycle latency. wr_bank and rd_bank pointers, and full[1:0] flags.
- Write side:
  - On an edge with en_in=1 and full[wr_bank]=0, write {xin_re,xin_im} to wr_bank at address bitrev(cnt_in), with the N bits mirrored (bit i goes to bit N-1-i).
  - The write counter is cnt_in itself; no internal counter. Gaps in en_in only pause writing.
  - On the write with cnt_in=2^N-1, set full[wr_bank] and toggle wr_bank on the same edge.
  - If en_in=1 while full[wr_bank]=1, suppress the write and set ovf=1. ovf stays set until reset.
- Read FSM, states IDLE and READ:
  - IDLE: if full[rd_bank]=1, go to READ with rd_addr=0.
  - READ: issue a read of rd_bank at rd_addr and increment rd_addr each cycle.
  - When rd_addr=2^N-1 is issued: clear full[rd_bank] and toggle rd_bank. If full of the other bank is already set, stay in READ with rd_addr=0, so back-to-back frames have no bubble. Otherwise go to IDLE.
  - A full flag set and cleared on the same edge (different banks) are independent; the set always wins for its own bank.
- Output pipeline:
  - Stage 1: RAM read. A valid/index shadow pipeline carries (read issued, rd_addr).
  - Stage 2: output registers. en_out = shadow valid, cnt_out = shadow index, yout = RAM data.
  - When no sample is valid, yout_re/yout_im hold 0 and cnt_out holds 0.
- Latency: if edge T captures the last input sample of a frame (cnt_in=2^N-1), then natural index 0 appears on the outputs at edge T+3. Indices 1..2^N-1 follow on consecutive edges.
- Continuous input at 1 sample/clk into N-stage-aligned frames never overflows.
- Reset (areset=1 at an edge):
  - Cleared: en_out=0, cnt_out=0, yout_re=0, yout_im=0, ovf=0, full=00, wr_bank=0, rd_bank=0, FSM=IDLE, rd_addr=0, shadow pipeline cleared.
  - RAM contents are not cleared. A partially written or partially read frame is discarded; outputs stop immediately.

Optional Feature:
BITREV_SOP_EOP_EN:
- Defined: adds output ports sop (1) and eop (1), registered alongside en_out. sop=1 with cnt_out=0 and en_out=1; eop=1 with cnt_out=2^N-1 and en_out=1. Both reset to 0.
- Undefined: the ports and their logic are absent; all other behaviour is identical.

Test Plan:
- N=3, one frame, en_in=1 for 8 cycles, cnt_in=0..7, xin_re=cnt_in, xin_im=-cnt_in -> 3 cycles after the last input, en_out=1 for 8 cycles with cnt_out=0..7 and yout_re=0,4,2,6,1,5,3,7 (yout_im negated); then en_out=0, ovf=0.
- N=3, three back-to-back frames, frame f with xin_re=8f+cnt_in -> 24 contiguous valid outputs with no bubble. Frame f yields 8f+{0,4,2,6,1,5,3,7}.
- N=3, en_in toggling 1/0 every cycle across one frame -> output identical to scenario 1, starting 3 cycles after the last input.
- Overrun, N=3: hold the reader stalled by asserting areset only on the read path via force, or feed 3 frames with both banks full -> writes into a full bank are suppressed, ovf=1 and stays 1; frames already in banks are output intact.
- areset=1 mid-readout at output index 4 -> next edge en_out=0, yout=0, ovf=0. A fresh frame then reads out correctly from index 0.
- With BITREV_SOP_EOP_EN on scenario 2 -> sop at cnt_out=0 and eop at cnt_out=7 for each of the 3 frames, exactly one cycle each.
